// File: rtl/lz_token_packer_pkg.sv
// rtl/lz_token_packer_pkg.sv - shared LZ token constants, FSM state enum and range helper
package lz_token_packer_pkg;

  // Token value map coming out of the LZ77 match datapath
  localparam int unsigned LIT_MAX       = 255;
  localparam int unsigned END_TOK       = 256;
  localparam int unsigned LEN_CODE_BASE = 257;
  localparam int unsigned LEN_CODE_MAX  = 285;

  // Legal ranges of the length/distance payload tokens
  localparam int unsigned LEN_MIN  = 3;
  localparam int unsigned LEN_MAX  = 64;
  localparam int unsigned DIST_MIN = 1;
  localparam int unsigned DIST_MAX = 64;

  // Record widths appended to the bit stream
  localparam int unsigned LIT_BITS   = 9;
  localparam int unsigned MATCH_BITS = 15;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DIST,
    FLUSH,
    DONE
  } lz_state_e;

  // Inclusive range test on a zero-extended token value
  function automatic logic in_range(input logic [31:0] v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/lz_bit_accum.sv
// rtl/lz_bit_accum.sv - LSB-first bit accumulator with byte drain
module lz_bit_accum #(
  parameter int ACC_W = 32,
  parameter int APP_W = 15,
  parameter int CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_app_valid,
  input  logic [APP_W-1:0] i_app_data,
  input  logic [CNT_W-1:0] i_app_width,
  input  logic             i_flush,
  output logic             o_byte_valid,
  output logic [7:0]       o_byte_data,
  input  logic             i_byte_ready,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_drain;
  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;

  // A whole byte is always offered; a partial one only while flushing.
  // Bits above r_bit_cnt are kept at zero, so a partial byte is zero-padded.
  assign o_byte_valid = (r_bit_cnt >= BYTE_BITS) || (i_flush && (r_bit_cnt != '0));
  assign o_byte_data  = r_acc[7:0];
  assign o_bit_cnt    = r_bit_cnt;
  assign w_drain      = o_byte_valid && i_byte_ready;

  // Drain happens first so a same-cycle append lands just above the remaining bits
  always_comb begin
    w_acc_base = r_acc;
    w_cnt_base = r_bit_cnt;
    if (w_drain) begin
      w_acc_base = r_acc >> 8;
      w_cnt_base = (r_bit_cnt >= BYTE_BITS) ? (r_bit_cnt - BYTE_BITS) : '0;
    end
  end

  // Accumulator and fill-level update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
    end else if (i_app_valid) begin
      r_acc     <= w_acc_base | (ACC_W'(i_app_data) << w_cnt_base);
      r_bit_cnt <= w_cnt_base + i_app_width;
    end else begin
      r_acc     <= w_acc_base;
      r_bit_cnt <= w_cnt_base;
    end
  end

endmodule

// File: rtl/lz_token_packer.sv
// rtl/lz_token_packer.sv - packs LZ77 literal/match tokens into an LSB-first byte stream
module lz_token_packer
  import lz_token_packer_pkg::*;
#(
  parameter int TOK_W   = 16,
  parameter int FIELD_W = 7,
  parameter int ACC_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  input  logic [TOK_W-1:0] tok_data,
  output logic             tok_ready,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  // Largest fill level that still leaves room for the widest record
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ACC_W - MATCH_BITS);

  lz_state_e          r_state;
  logic [FIELD_W-1:0] r_len;
  logic               r_err;
  logic               r_done;

  logic [31:0]           w_tok;
  logic                  w_accept;
  logic                  w_is_lit;
  logic                  w_is_end;
  logic                  w_is_len_code;
  logic                  w_app_valid;
  logic [MATCH_BITS-1:0] w_app_data;
  logic [CNT_W-1:0]      w_app_width;
  logic [CNT_W-1:0]      w_bit_cnt;
  logic                  w_flush;

  assign w_tok         = 32'(tok_data);
  assign w_is_lit      = (w_tok <= LIT_MAX);
  assign w_is_end      = (w_tok == END_TOK);
  assign w_is_len_code = in_range(w_tok, LEN_CODE_BASE, LEN_CODE_MAX);
  assign w_flush       = (r_state == FLUSH);

  // rst_n gates ready so nothing is offered while reset is held
  assign tok_ready = rst_n
                   && ((r_state == IDLE) || (r_state == GET_LEN) || (r_state == GET_DIST))
                   && (w_bit_cnt <= READY_MAX);
  assign w_accept  = tok_valid && tok_ready;

  assign done = r_done;
  assign err  = r_err;

  // Choose which record, if any, the accepted token appends
  always_comb begin
    w_app_valid = 1'b0;
    w_app_data  = '0;
    w_app_width = '0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_is_lit) begin
            w_app_valid = 1'b1;
            w_app_data  = MATCH_BITS'({tok_data[7:0], 1'b0});
            w_app_width = CNT_W'(LIT_BITS);
          end else if (w_is_end) begin
            w_app_valid = 1'b1;
            w_app_data  = MATCH_BITS'(1);
            w_app_width = CNT_W'(MATCH_BITS);
          end
        end
        GET_DIST: begin
          w_app_valid = 1'b1;
          w_app_data  = MATCH_BITS'({tok_data[FIELD_W-1:0], r_len, 1'b1});
          w_app_width = CNT_W'(MATCH_BITS);
        end
        default: ;
      endcase
    end
  end

  // Token-level FSM; err is sticky, done is high only for the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_end) begin
              r_state <= FLUSH;
            end else if (w_is_len_code) begin
              r_state <= GET_LEN;
            end else if (!w_is_lit) begin
              r_err <= 1'b1;
            end
          end
        end
        GET_LEN: begin
          if (w_accept) begin
            r_len <= tok_data[FIELD_W-1:0];
            if (!in_range(w_tok, LEN_MIN, LEN_MAX)) begin
              r_err <= 1'b1;
            end
            r_state <= GET_DIST;
          end
        end
        GET_DIST: begin
          if (w_accept) begin
            if (!in_range(w_tok, DIST_MIN, DIST_MAX)) begin
              r_err <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (w_bit_cnt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  lz_bit_accum #(
    .ACC_W (ACC_W),
    .APP_W (MATCH_BITS),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_app_valid  (w_app_valid),
    .i_app_data   (w_app_data),
    .i_app_width  (w_app_width),
    .i_flush      (w_flush),
    .o_byte_valid (byte_valid),
    .o_byte_data  (byte_data),
    .i_byte_ready (byte_ready),
    .o_bit_cnt    (w_bit_cnt)
  );

endmodule

// File: tb/tb_lz_token_packer.sv
// tb/tb_lz_token_packer.sv - scoreboard bench for lz_token_packer
module tb_lz_token_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tok_valid = 1'b0;
  logic [15:0] tok_data = '0;
  logic        tok_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b0;
  logic        done;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;

  // stimulus queue and scoreboard
  int         tok_q[$];
  logic [7:0] exp_q[$];
  bit         m_bits[$];
  int         m_st;
  int         m_len;
  int         exp_done;
  bit         m_err;

  // per-stream observations
  int got_done;
  int hold_accepts;
  int first_hold;
  int hold_bad;
  bit timed_out;

  always #5 clk = ~clk;

  lz_token_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tok_valid  (tok_valid),
    .tok_data   (tok_data),
    .tok_ready  (tok_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .done       (done),
    .err        (err)
  );

  task automatic model_reset(input bit clear_err);
    m_st = 0;
    m_len = 0;
    exp_done = 0;
    m_bits.delete();
    exp_q.delete();
    tok_q.delete();
    if (clear_err) m_err = 1'b0;
  endtask

  task automatic emit_bytes(input bit partial);
    logic [7:0] b;
    while (m_bits.size() >= 8 || (partial && m_bits.size() > 0)) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        if (m_bits.size() > 0) b[i] = m_bits.pop_front();
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic push_bits(input int val, input int w);
    for (int i = 0; i < w; i++) m_bits.push_back(val[i]);
    emit_bytes(1'b0);
  endtask

  // queue a token and advance the reference model
  task automatic push_tok(input int t);
    tok_q.push_back(t);
    case (m_st)
      0: begin
        if (t <= 255) begin
          push_bits(t << 1, 9);
        end else if (t == 256) begin
          push_bits(1, 15);
          emit_bytes(1'b1);
          exp_done++;
        end else if (t <= 285) begin
          m_st = 1;
        end else begin
          m_err = 1'b1;
        end
      end
      1: begin
        m_len = t & 127;
        if (t < 3 || t > 64) m_err = 1'b1;
        m_st = 2;
      end
      default: begin
        push_bits(((t & 127) << 8) | (m_len << 1) | 1, 15);
        if (t < 1 || t > 64) m_err = 1'b1;
        m_st = 0;
      end
    endcase
  endtask

  // drive queued tokens, pop/compare bytes as they transfer
  task automatic drive_stream(input string name, input int hold, input bit rnd, input int budget);
    int         cyc = 0;
    int         extra = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_b;
    got_done = 0;
    hold_accepts = 0;
    first_hold = -1;
    hold_bad = 0;
    timed_out = 1'b0;
    while (extra < 4) begin
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      tok_valid = (tok_q.size() != 0);
      tok_data = tok_valid ? 16'(tok_q[0]) : 16'h0;
      byte_ready = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      if (prev_stall && (!byte_valid || byte_data !== prev_data)) hold_bad++;
      if (byte_valid && !byte_ready && first_hold < 0) first_hold = int'(byte_data);
      if (done === 1'b1) got_done++;
      if (tok_valid && tok_ready) begin
        void'(tok_q.pop_front());
        if (cyc < hold) hold_accepts++;
      end
      if (byte_valid && byte_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra_byte got=%h required=none", name, byte_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (byte_data !== exp_b) begin
            n_bad++;
            $display("FAIL %s byte got=%h required=%h", name, byte_data, exp_b);
          end
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data = byte_data;
      if (tok_q.size() == 0 && exp_q.size() == 0 && got_done >= exp_done) extra++;
      cyc++;
    end
    tok_valid = 1'b0;
    tok_data = '0;
    byte_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (tok_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tok_ready got=%b required=0", tok_ready); end
    n_total++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_byte_valid got=%b required=0", byte_valid); end
    n_total++; if (byte_data !== 8'h00) begin n_bad++; $display("FAIL rst_byte_data got=%h required=00", byte_data); end
    n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b required=0", done); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b required=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (tok_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b required=1", tok_ready); end
  endtask

  task automatic test_literals();
    model_reset(1'b0);
    push_tok(8'h41); push_tok(8'h42); push_tok(256);
    drive_stream("literals", 0, 1'b0, 200);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL literals_timeout got=1 required=0"); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL literals_missing got=%0d required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL literals_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL literals_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_match();
    model_reset(1'b0);
    push_tok(259); push_tok(5); push_tok(3); push_tok(256);
    drive_stream("match", 0, 1'b0, 200);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL match_timeout got=1 required=0"); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL match_missing got=%0d required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL match_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL match_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_backpressure();
    model_reset(1'b0);
    push_tok(259); push_tok(5); push_tok(3); push_tok(256);
    drive_stream("bp_match", 20, 1'b0, 300);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_match_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (first_hold != 32'h0B) begin n_bad++; $display("FAIL bp_match_held got=%0h required=b", first_hold); end
    n_total++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_match_stable got=%0d required=0", hold_bad); end
    n_total++; if (hold_accepts != 4) begin n_bad++; $display("FAIL bp_match_accepts got=%0d required=4", hold_accepts); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL bp_match_done got=%0d required=%0d", got_done, exp_done); end
    // literals keep the FSM in IDLE so only the fill level can stall it
    model_reset(1'b0);
    push_tok(259); push_tok(5); push_tok(3); push_tok(8'h41); push_tok(8'h42); push_tok(256);
    drive_stream("bp_fill", 20, 1'b0, 300);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_fill_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (hold_accepts != 4) begin n_bad++; $display("FAIL bp_fill_accepts got=%0d required=4", hold_accepts); end
    n_total++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_fill_stable got=%0d required=0", hold_bad); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL bp_fill_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_random();
    model_reset(1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          push_tok(int'($urandom_range(257, 285)));
          push_tok(int'($urandom_range(3, 64)));
          push_tok(int'($urandom_range(1, 64)));
        end else begin
          push_tok(int'($urandom_range(0, 255)));
        end
      end
      push_tok(256);
    end
    drive_stream("random", 0, 1'b1, 3000);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL random_timeout got=1 required=0"); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL random_missing got=%0d required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL random_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL random_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_bad_len();
    model_reset(1'b0);
    push_tok(257); push_tok(2); push_tok(5); push_tok(256);
    drive_stream("bad_len", 0, 1'b0, 200);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL bad_len_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL bad_len_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL bad_len_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_reset_mid_record();
    model_reset(1'b0);
    push_tok(259); push_tok(5);
    drive_stream("mid_rec", 0, 1'b0, 100);
    n_total++; if (timed_out || tok_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rec_pending got=%b required=1", tok_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({tok_ready, byte_valid, byte_data, done, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL mid_rec_reset_outs got=%b%b%h%b%b required=0", tok_ready, byte_valid, byte_data, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b1);
    push_tok(8'h41); push_tok(256);
    drive_stream("post_rst", 0, 1'b0, 200);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL post_rst_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL post_rst_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL post_rst_err got=%b required=%b", err, m_err); end
  endtask

  task automatic test_bad_token();
    model_reset(1'b0);
    push_tok(300); push_tok(256);
    drive_stream("bad_tok", 0, 1'b0, 200);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL bad_tok_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (got_done != exp_done) begin n_bad++; $display("FAIL bad_tok_done got=%0d required=%0d", got_done, exp_done); end
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_tok_err got=%b required=1", err); end
    // err stays set across a clean block
    model_reset(1'b0);
    push_tok(8'h41); push_tok(256);
    drive_stream("sticky", 0, 1'b0, 200);
    n_total++; if (timed_out || exp_q.size() != 0) begin n_bad++; $display("FAIL sticky_drain got=%0d left required=0", exp_q.size()); end
    n_total++; if (err !== m_err) begin n_bad++; $display("FAIL sticky_err got=%b required=%b", err, m_err); end
  endtask

  initial begin
    m_err = 1'b0;
    test_reset();
    test_literals();
    test_match();
    test_backpressure();
    test_random();
    test_bad_len();
    test_reset_mid_record();
    test_bad_token();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lz_token_packer.md
LZ_TOKEN_PACKER -- requirements
Module: lz_token_packer

Interface
REQ-001 SHALL have parameter TOK_W, default 16, giving the width of the incoming LZ token.
REQ-002 SHALL have parameter FIELD_W, default 7, giving the width of the length and distance fields.
REQ-003 SHALL have parameter ACC_W, default 32, giving the width of the bit accumulator.
REQ-004 clk  input  1  the one clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tok_valid  input  1  a token is present on tok_data.
REQ-007 tok_data  input  TOK_W  token stream from the LZ77 match datapath.
- 0..255: literal.
- 256: end of block.
- 257..285: length code; the next two tokens are length, then distance.
REQ-008 tok_ready  output  1  the packer accepts tok_data this cycle.
REQ-009 byte_valid  output  1  byte_data holds a packed output byte.
REQ-010 byte_data  output  8  packed byte, first-in bits at bit 0.
REQ-011 byte_ready  input  1  the downstream stage takes the byte.
REQ-012 done  output  1  one-cycle pulse after the last byte of a block drains.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 A token transfer SHALL occur only on a cycle where tok_valid and tok_ready are both 1; a byte transfer SHALL occur only where byte_valid and byte_ready are both 1.
REQ-015 The FSM SHALL have states IDLE, GET_LEN, GET_DIST, FLUSH, DONE.
REQ-016 IDLE behaviour per accepted token:
- literal L: append 9 bits {L, 1'b0}, LSB-first; stay in IDLE.
- 257..285: emit nothing; go to GET_LEN.
- 256: append end record (15 bits, value 1); go to FLUSH.
REQ-017 In IDLE, a token value of 286 or more SHALL be dropped and SHALL set err.
REQ-018 GET_LEN SHALL latch tok_data[FIELD_W-1:0] as length and go to GET_DIST; a length outside 3..64 SHALL set err but still be used.
REQ-019 GET_DIST SHALL append 15 bits {dist[6:0], len[6:0], 1'b1} and go to IDLE; a distance outside 1..64 SHALL set err but still be used.
REQ-020 tok_ready SHALL be 1 only in IDLE, GET_LEN or GET_DIST, and only when bit_cnt is 17 or less (ACC_W-15), so the accumulator never overflows.
REQ-021 byte_valid SHALL be (bit_cnt >= 8) or (state is FLUSH and bit_cnt > 0); byte_data SHALL be acc[7:0], with unfilled upper bits equal to 0.
REQ-022 When a byte drains and a token is appended in the same cycle, the accumulator SHALL:
- shift right by 8 first;
- then OR the new bits in at bit (bit_cnt-8);
- set bit_cnt to bit_cnt-8+w, where w is the appended width.
REQ-023 A partial final byte in FLUSH SHALL drain and set bit_cnt to 0.
REQ-024 FLUSH SHALL go to DONE when bit_cnt is 0; DONE SHALL assert done for one cycle and go to IDLE.
REQ-025 byte_data and byte_valid SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 While rst_n=0, the block SHALL force: state IDLE, acc 0, bit_cnt 0, latched length 0, tok_ready 0, byte_valid 0, byte_data 0, done 0, err 0.
REQ-028 Reset asserted mid-record or mid-flush SHALL discard all buffered bits without emitting them.
REQ-029 After rst_n rises, the first accept SHALL be possible on the first rising edge.

Structure
REQ-030 The shared LZ package SHALL hold these constants: LIT_MAX=255, END_TOK=256, LEN_CODE_BASE=257, LEN_CODE_MAX=285, LEN_MIN=3, LEN_MAX=64, DIST_MAX=64, LIT_BITS=9, MATCH_BITS=15.
REQ-031 The shared LZ package SHALL hold the FSM state enum.
REQ-032 The accumulator and byte drain SHALL be one sub-module, lz_bit_accum, with an append (data, width) input and a byte valid/ready output.

Verification
REQ-033 Tokens 0x41, 0x42, 256 with byte_ready=1 -> bytes 0x82, 0x08, 0x05, 0x00, 0x00, then done pulse; err=0.
REQ-034 Tokens 259, 5, 3, 256 -> bytes 0x0B, 0x83, 0x00, 0x00, then done; err=0.
REQ-035 Same as REQ-034 with byte_ready held 0 for 20 cycles -> tok_ready falls when bit_cnt>17, byte_data holds 0x0B, no byte lost or duplicated.
REQ-036 Token 300, then 256 -> err=1, bytes 0x01, 0x00, then done.
REQ-037 rst_n pulsed low after 259, 5 -> all outputs 0 immediately; a following 0x41, 256 yields bytes 0x82, 0x02, 0x00.
